// File: rtl/posit_defines_pkg.sv
// Shared posit datapath definitions: aggregate widths,
// rounding mode codes and the LFSR reset value.
package posit_defines;

  typedef enum logic [1:0] {
    NORMAL,
    AADD,
    AMULT
  } pd_type;

  localparam logic [2:0] RZERO      = 3'd0;
  localparam logic [2:0] RNTE       = 3'd1;
  localparam logic [2:0] RPLUSINF   = 3'd2;
  localparam logic [2:0] RMININF    = 3'd3;
  localparam logic [2:0] STOCHASTIC = 3'd4;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  function automatic int get_fraction_width(
    int n, int es, pd_type t
  );
    int fw;
    fw = n - es - 3;
    if (t == AMULT) return 2 * (fw + 1);
    if (t == AADD) return fw + 3;
    return fw;
  endfunction

  function automatic int get_scale_width(
    int n, int es, pd_type t
  );
    int sw;
    sw = $clog2((n - 1) << es) + 1;
    return (t == NORMAL) ? sw : sw + 1;
  endfunction

  function automatic int get_max_scale(int n, int es);
    return (n - 2) << es;
  endfunction

endpackage

// File: rtl/posit_round_pipe_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) used as
// the random source for stochastic rounding.
module posit_lfsr16
  import posit_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        seed_we,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;
  logic        fb;

  always_comb begin
    fb = lfsr_q[15] ^ lfsr_q[13]
       ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = lfsr_q;
    // a zero seed would lock the register up
    if (seed_we)
      lfsr_d = (seed == '0) ? LFSR_RESET : seed;
    else if (step)
      lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_RESET;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/posit_round_pipe.sv
// Two-stage elastic posit rounding stage: S1 decides the
// round-up, S2 applies it with scale saturation.
module posit_round_pipe
  import posit_defines::*;
#(
  parameter int     POSIT_WIDTH = 16,
  parameter int     POSIT_ES    = 1,
  parameter pd_type IN_PDT      = AMULT,
  localparam int SW_IN =
    get_scale_width(POSIT_WIDTH, POSIT_ES, IN_PDT),
  localparam int FW_IN =
    get_fraction_width(POSIT_WIDTH, POSIT_ES, IN_PDT),
  localparam int SW =
    get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL),
  localparam int FW =
    get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [SW_IN-1:0] in_scale,
  input  logic [FW_IN-1:0] in_frac,
  input  logic             in_nar,
  input  logic             in_zero,
  input  logic [2:0]       in_rnd,
  input  logic             seed_we,
  input  logic [15:0]      seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [SW-1:0]    out_scale,
  output logic [FW-1:0]    out_frac,
  output logic             out_nar,
  output logic             out_zero,
  output logic             out_inexact
);

  localparam int DW   = FW_IN - FW;
  localparam int MAXS =
    get_max_scale(POSIT_WIDTH, POSIT_ES);
  localparam logic signed [SW_IN:0] MAXS_E =
    (SW_IN + 1)'(MAXS);
  localparam logic [DW-1:0] SMASK =
    DW'((32'd1 << (DW - 1)) - 32'd1);

  if (DW < 1 || DW > 16) begin : g_dw_chk
    $error("posit_round_pipe: DW must be 1..16");
  end

  typedef struct packed {
    logic             sign;
    logic [SW_IN-1:0] scale;
    logic [FW-1:0]    k;
    logic             up;
    logic             inex;
    logic             nar;
    logic             zero;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic          nar;
    logic          zero;
    logic          inex;
  } s2_t;

  logic        s1_v_d, s1_v_q;
  logic        s2_v_d, s2_v_q;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q, res;
  logic        s1_ld, s2_ld, in_fire;
  logic [15:0] lfsr_q;
  logic        unused_lfsr;

  logic [FW-1:0]          k;
  logic [DW-1:0]          d;
  logic                   g, s, up;
  logic [FW:0]            sum;
  logic signed [SW_IN:0]  se;

  assign s2_ld    = !s2_v_q | out_ready;
  assign s1_ld    = !s1_v_q | s2_ld;
  assign in_ready = s1_ld;
  assign in_fire  = in_valid & s1_ld;

  posit_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (in_fire),
    .seed_we (seed_we),
    .seed    (seed),
    .q       (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q;

  always_comb begin
    k  = in_frac[FW_IN-1 -: FW];
    d  = in_frac[DW-1:0];
    g  = d[DW-1];
    s  = |(d & SMASK);
    up = 1'b0;
    unique case (in_rnd)
      RZERO:      up = 1'b0;
      RPLUSINF:   up = !in_sign & (g | s);
      RMININF:    up = in_sign & (g | s);
      STOCHASTIC: up = lfsr_q[DW-1:0] < d;
      default:    up = g & (s | k[0]);
    endcase
  end

  always_comb begin
    s1_v_d = s1_ld ? in_valid : s1_v_q;
    s1_d   = s1_q;
    if (in_fire) begin
      s1_d.sign  = in_sign;
      s1_d.scale = in_scale;
      s1_d.k     = k;
      s1_d.up    = up;
      s1_d.inex  = g | s;
      s1_d.nar   = in_nar;
      s1_d.zero  = in_zero;
    end
  end

  always_comb begin
    res  = '0;
    sum  = {1'b0, s1_q.k}
         + {{FW{1'b0}}, s1_q.up};
    se   = $signed({s1_q.scale[SW_IN-1], s1_q.scale})
         + $signed({{SW_IN{1'b0}}, sum[FW]});
    res.sign = s1_q.sign;
    res.nar  = s1_q.nar;
    res.zero = s1_q.zero;
    res.inex = s1_q.inex;
    res.frac = sum[FW] ? '0 : sum[FW-1:0];
    // posits saturate instead of reaching zero or NaR
    if (se > MAXS_E) begin
      res.scale = SW'(MAXS_E);
      res.frac  = '1;
    end else if (se < -MAXS_E) begin
      res.scale = SW'(-MAXS_E);
      res.frac  = '0;
    end else begin
      res.scale = SW'(se);
    end
    if (s1_q.nar | s1_q.zero) begin
      res.scale = '0;
      res.frac  = '0;
      res.inex  = 1'b0;
    end
  end

  always_comb begin
    s2_v_d = s2_ld ? s1_v_q : s2_v_q;
    s2_d   = s2_q;
    if (s2_ld & s1_v_q) s2_d = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_sign    = s2_q.sign;
  assign out_scale   = s2_q.scale;
  assign out_frac    = s2_q.frac;
  assign out_nar     = s2_q.nar;
  assign out_zero    = s2_q.zero;
  assign out_inexact = s2_q.inex;

endmodule

// File: tb/tb_posit_round_pipe.sv
// Randomized scoreboard bench for posit_round_pipe
// (N=16, ES=1, AMULT input) plus directed corner cases.
module tb_posit_round_pipe;

  localparam int FW   = 12;
  localparam int FWI  = 26;
  localparam int DW   = 14;
  localparam int SWI  = 7;
  localparam int SW   = 6;
  localparam int MAXS = 28;

  localparam logic [2:0] R_Z  = 3'd0;
  localparam logic [2:0] R_NE = 3'd1;
  localparam logic [2:0] R_PI = 3'd2;
  localparam logic [2:0] R_MI = 3'd3;
  localparam logic [2:0] R_ST = 3'd4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_sign = 1'b0;
  logic [SWI-1:0] in_scale = '0;
  logic [FWI-1:0] in_frac = '0;
  logic           in_nar = 1'b0;
  logic           in_zero = 1'b0;
  logic [2:0]     in_rnd = '0;
  logic           seed_we = 1'b0;
  logic [15:0]    seed = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_sign;
  logic [SW-1:0]  out_scale;
  logic [FW-1:0]  out_frac;
  logic           out_nar;
  logic           out_zero;
  logic           out_inexact;
  logic [21:0]    obs;

  always #5 clk = ~clk;

  posit_round_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_scale    (in_scale),
    .in_frac     (in_frac),
    .in_nar      (in_nar),
    .in_zero     (in_zero),
    .in_rnd      (in_rnd),
    .seed_we     (seed_we),
    .seed        (seed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_scale   (out_scale),
    .out_frac    (out_frac),
    .out_nar     (out_nar),
    .out_zero    (out_zero),
    .out_inexact (out_inexact)
  );

  assign obs = {out_sign, out_scale, out_frac,
                out_nar, out_zero, out_inexact};

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic [21:0] exp_q[$];
  logic [15:0] mdl_lfsr = 16'hACE1;
  logic        acc_in = 1'b0;
  logic        stall_prev = 1'b0;
  logic [21:0] held = '0;
  logic [21:0] last_out = '0;
  bit          st_on = 1'b0;
  int          st_idx = 0;
  bit          st_bits[1000];
  bit          st_ref[1000];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(
    logic [15:0] v
  );
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // Rounding reference in plain integer arithmetic.
  function automatic logic [21:0] ref_round(
    logic sg, logic signed [SWI-1:0] sc,
    logic [FWI-1:0] fr, logic nar, logic zero,
    logic [2:0] rnd, logic [15:0] lf
  );
    int k, rem, half, scl;
    bit up, inex;
    k    = int'(fr) >> DW;
    rem  = int'(fr) & ((1 << DW) - 1);
    half = 1 << (DW - 1);
    case (rnd)
      R_Z:     up = 1'b0;
      R_PI:    up = !sg && rem != 0;
      R_MI:    up = sg && rem != 0;
      R_ST:    up = (int'(lf) & ((1 << DW) - 1)) < rem;
      default: up = rem > half ||
                    (rem == half && k % 2 == 1);
    endcase
    k   = k + int'(up);
    scl = int'(sc);
    if (k == (1 << FW)) begin
      k   = 0;
      scl = scl + 1;
    end
    if (scl > MAXS) begin
      scl = MAXS;
      k   = (1 << FW) - 1;
    end else if (scl < -MAXS) begin
      scl = -MAXS;
      k   = 0;
    end
    inex = rem != 0;
    if (nar || zero) begin
      scl  = 0;
      k    = 0;
      inex = 1'b0;
    end
    return {sg, SW'(scl), FW'(k), nar, zero, inex};
  endfunction

  task automatic sample();
    acc_in = in_valid && in_ready;
    if (out_valid && stall_prev) chk("hold", obs, held);
    if (out_valid && out_ready) begin
      if (exp_q.size() != 0)
        chk("out", obs, exp_q.pop_front());
      last_out = obs;
      n_out++;
      if (st_on && st_idx < 1000) begin
        st_bits[st_idx] = out_frac[0];
        st_idx++;
      end
    end
    stall_prev = out_valid && !out_ready;
    held = obs;
    if (acc_in) begin
      n_acc++;
      exp_q.push_back(ref_round(in_sign, in_scale,
        in_frac, in_nar, in_zero, in_rnd, mdl_lfsr));
    end
    if (seed_we)
      mdl_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    else if (acc_in)
      mdl_lfsr = lfsr_next(mdl_lfsr);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic sg, logic [SWI-1:0] sc,
                        logic [FWI-1:0] fr, logic [2:0] rnd,
                        logic nar, logic zero);
    in_sign  = sg;
    in_scale = sc;
    in_frac  = fr;
    in_rnd   = rnd;
    in_nar   = nar;
    in_zero  = zero;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), SWI'($urandom), FWI'($urandom),
           3'($urandom_range(0, 7)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0);
  endtask

  task automatic send(logic sg, logic [SWI-1:0] sc,
                      logic [FWI-1:0] fr, logic [2:0] rnd,
                      logic nar, logic zero);
    set_in(sg, sc, fr, rnd, nar, zero);
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (acc_in) break;
    end
    chk("send_acc", acc_in, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++)
      tick();
    tick();
    tick();
    chk("drain_cnt", n_out, n_acc);
  endtask

  task automatic stoch_run();
    int sent = 0;
    seed_we = 1'b1;
    seed    = 16'h0001;
    tick();
    seed_we = 1'b0;
    st_on   = 1'b1;
    st_idx  = 0;
    set_in(1'b0, '0, 26'h0002000, R_ST, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int t = 0; t < 2000 && sent < 1000; t++) begin
      tick();
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    drain();
    st_on = 1'b0;
    chk("st_sent", sent, 1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, got, base, ups, ndiff;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", obs, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_ready", in_ready, 1);

    send(1'b0, 7'd0, 26'h0006000, R_NE, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2);
    drain();
    chk("tie_odd_frac", last_out[14:3], 12'h002);
    chk("tie_odd_inex", last_out[0], 1);
    send(1'b0, 7'd0, 26'h0002000, R_NE, 1'b0, 1'b0);
    drain();
    chk("tie_even_frac", last_out[14:3], 12'h000);

    send(1'b0, 7'd5, 26'h3FFC001, R_PI, 1'b0, 1'b0);
    drain();
    chk("carry_scale", last_out[20:15], 6'd6);
    chk("carry_frac", last_out[14:3], 12'h000);
    send(1'b1, 7'd5, 26'h3FFC001, R_PI, 1'b0, 1'b0);
    drain();
    chk("neg_scale", last_out[20:15], 6'd5);
    chk("neg_frac", last_out[14:3], 12'hFFF);

    send(1'b0, 7'd28, 26'h3FFE000, R_PI, 1'b0, 1'b0);
    drain();
    chk("sat_hi_scale", last_out[20:15], 6'h1C);
    chk("sat_hi_frac", last_out[14:3], 12'hFFF);
    send(1'b0, -7'sd29, 26'h3FFE000, R_PI, 1'b0, 1'b0);
    send(1'b1, -7'sd40, 26'h0000001, R_MI, 1'b0, 1'b0);
    drain();
    chk("sat_lo_scale", last_out[20:15], 6'h24);
    chk("sat_lo_frac", last_out[14:3], 12'h000);

    base = n_out;
    got = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || acc_in) rand_in();
      in_valid = 1'b1;
      tick();
      if (acc_in) got++;
    end
    chk("bp_acc", got, 2);
    chk("bp_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int t = 0; t < 50 && got < 4; t++) begin
      if (acc_in) rand_in();
      tick();
      if (acc_in) got++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_out", n_out - base, 4);

    stoch_run();
    ups = 0;
    for (int i = 0; i < 1000; i++) begin
      ups += int'(st_bits[i]);
      st_ref[i] = st_bits[i];
    end
    chk("st_range", (ups >= 450 && ups <= 550), 1);
    stoch_run();
    ndiff = 0;
    for (int i = 0; i < 1000; i++)
      if (st_bits[i] != st_ref[i]) ndiff++;
    chk("st_repeat", ndiff, 0);

    for (int c = 0; c < 3000; c++) begin
      rand_in();
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      seed_we   = $urandom_range(0, 49) == 0;
      seed = ($urandom_range(0, 3) == 0) ?
             16'h0 : 16'($urandom);
      tick();
    end
    seed_we = 1'b0;
    drain();

    out_ready = 1'b0;
    send(1'b0, 7'd3, 26'h1234567, R_NE, 1'b0, 1'b0);
    send(1'b1, 7'd4, 26'h0ABCDEF, R_NE, 1'b0, 1'b0);
    chk("full_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_lfsr", dut.u_lfsr.q, 16'hACE1);
    exp_q.delete();
    n_acc = 0;
    n_out = 0;
    stall_prev = 1'b0;
    mdl_lfsr = 16'hACE1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b0, 7'd9, 26'h0FFFFFF, R_PI, 1'b1, 1'b0);
    drain();
    chk("nar_flag", last_out[2], 1);
    chk("nar_inex", last_out[0], 0);
    chk("nar_frac", last_out[14:3], 12'h000);
    send(1'b0, 7'd9, 26'h0FFFFFF, R_PI, 1'b0, 1'b1);
    drain();
    chk("zero_flag", last_out[1], 1);
    chk("zero_scale", last_out[20:15], 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
